// File: rtl/fetch_unit.sv
// RV32I instruction fetch front end: owns the PC, issues credit-limited word fetches,
// buffers in-order responses and hands them to decode; redirects flush buffered and in-flight words.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0]           word;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    state_t                state_q, state_n;
    logic                  req_q, req_n;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_n;
    logic [CNT_W-1:0]      out_q, out_n;
    logic [CNT_W-1:0]      drop_q, drop_n;
    logic [CNT_W-1:0]      buf_cnt_n;
    logic [SUM_W-1:0]      credit_sum;
    logic [DEPTH-1:0]      vld_q, vld_n;
    entry_t                ent_q [DEPTH];
    entry_t                ent_n [DEPTH];
    logic [ADDR_WIDTH-1:0] pcq_q [DEPTH];
    logic [PTR_W-1:0]      pcq_wr_q, pcq_rd_q;
    logic                  accept, pop, push, placed;

    assign accept      = req_q & imem_ready;
    assign pop         = vld_q[0] & instr_ready;
    assign imem_req    = req_q;
    assign imem_addr   = fetch_pc_q;
    assign instr_valid = vld_q[0];
    assign instr       = ent_q[0].word;
    assign instr_pc    = ent_q[0].pc;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_n;
    end

    // FSM next state
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_RESET: state_n = S_RUN;
            S_RUN:   state_n = S_RUN;
            default: state_n = S_RESET;
        endcase
    end

    // Request for the coming cycle, from next-cycle credit (stale in-flight words still hold credit)
    always_comb begin
        req_n      = 1'b0;
        credit_sum = SUM_W'(out_n) + SUM_W'(buf_cnt_n);
        if (state_n == S_RUN && credit_sum < SUM_W'(DEPTH)) req_n = 1'b1;
    end

    // Buffer, PC, outstanding and drop bookkeeping
    always_comb begin
        fetch_pc_n = fetch_pc_q;
        drop_n     = drop_q;
        vld_n      = vld_q;
        ent_n      = ent_q;
        push       = 1'b0;
        placed     = 1'b0;
        buf_cnt_n  = '0;
        out_n      = out_q + CNT_W'(accept) - CNT_W'(imem_rvalid);

        if (accept) fetch_pc_n = fetch_pc_q + ADDR_WIDTH'(4);

        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                vld_n[i] = vld_q[i+1];
                ent_n[i] = ent_q[i+1];
            end
            vld_n[DEPTH-1] = 1'b0;
            ent_n[DEPTH-1] = '0;
        end

        if (imem_rvalid && !redirect) begin
            if (drop_q != '0) drop_n = drop_q - CNT_W'(1);
            else              push   = 1'b1;
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (push && !placed && !vld_n[i]) begin
                vld_n[i] = 1'b1;
                ent_n[i] = '{word: imem_rdata, pc: pcq_q[pcq_rd_q]};
                placed   = 1'b1;
            end
        end

        // Everything still in flight after this cycle belongs to the old path
        if (redirect) begin
            vld_n      = '0;
            fetch_pc_n = redirect_target & ~ADDR_WIDTH'(3);
            drop_n     = out_n;
        end

        for (int i = 0; i < int'(DEPTH); i++) buf_cnt_n = buf_cnt_n + CNT_W'(vld_n[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            vld_q      <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
                pcq_q[i] <= '0;
            end
        end else begin
            req_q      <= req_n;
            fetch_pc_q <= fetch_pc_n;
            out_q      <= out_n;
            drop_q     <= drop_n;
            vld_q      <= vld_n;
            ent_q      <= ent_n;
            if (accept) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q        <= pcq_wr_q + PTR_W'(1);
            end
            if (imem_rvalid) pcq_rd_q <= pcq_rd_q + PTR_W'(1);
        end
    end

    a_rvalid_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (out_q != '0));

endmodule
